// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus transmitter: FSM states, pulse defaults, line levels.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maple_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_END
  } state_e;

  localparam int DEF_START_PULSES = 4;
  localparam int DEF_END_PULSES   = 2;
  localparam int PULSE_W          = 4;    // pulse counter width, room for 8 pulses plus gap marker
  localparam logic LINE_IDLE      = 1'b1; // released lines are pulled high

  // Line levels {pin1, pin5} for one data sub-phase. Odd bit indices (7,5,3,1) use pin1 as
  // the clock line with pin5 carrying data; even indices swap the roles. half=1 is the
  // falling edge of the clock line where the receiver samples.
  function automatic logic [1:0] data_lines(input logic [2:0] idx, input logic half,
                                            input logic d);
    return idx[0] ? {~half, d} : {d, ~half};
  endfunction

endpackage

// File: rtl/maple_tx_if.sv
// Host/pad side signal bundle of the Maple transmitter.
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready handshake, byte accepted when both are high.
interface maple_tx_if;
  logic       tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       pin1;
  logic       pin5;
  logic       oe;
  logic       busy;
  logic       underrun;

  modport master (
    output tick, tx_data, tx_valid, tx_last,
    input  tx_ready, pin1, pin5, oe, busy, underrun
  );

  modport slave (
    input  tick, tx_data, tx_valid, tx_last,
    output tx_ready, pin1, pin5, oe, busy, underrun
  );
endinterface

// File: rtl/maple_tx_shifter.sv
// Byte holder for the transmitter: current byte, one-deep shadow byte, last flag, bit/half counter.
// Latency: next sub-phase values are combinational from the controls, registered on the same edge.
// Backpressure: shadow accepts one byte; a write on the reload cycle bypasses straight into the byte.
module maple_tx_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,          // first byte of a frame
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  input  logic       begin_data,  // enter bit 7 tick a
  input  logic       step,        // advance one sub-phase (reloads after bit 0 tick b)
  input  logic       shadow_wr,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       byte_done,
  output logic       shadow_full,
  output logic       last_flag,
  output logic [2:0] nxt_idx,
  output logic       nxt_half,
  output logic       nxt_bit
);
  import maple_pkg::*;

  logic [7:0] data_q, shadow_q, nxt_data;
  logic       last_q, shadow_last_q, shadow_vld_q, nxt_last;
  logic [2:0] idx_q;
  logic       half_q;

  assign byte_done   = (idx_q == 3'd0) & half_q;
  assign shadow_full = shadow_vld_q;
  assign last_flag   = last_q;

  // Next byte/counter position; index wraps 0->7 so the reload lands on bit 7.
  always_comb begin
    nxt_data = data_q;
    nxt_last = last_q;
    nxt_idx  = idx_q;
    nxt_half = half_q;
    if (ld) begin
      nxt_data = ld_data;
      nxt_last = ld_last;
    end
    if (begin_data) begin
      nxt_idx  = 3'd7;
      nxt_half = 1'b0;
    end else if (step) begin
      if (!half_q) begin
        nxt_half = 1'b1;
      end else begin
        nxt_half = 1'b0;
        nxt_idx  = idx_q - 3'd1;
        if (idx_q == 3'd0) begin
          if (shadow_vld_q) begin
            nxt_data = shadow_q;
            nxt_last = shadow_last_q;
          end else begin
            nxt_data = wr_data;
            nxt_last = wr_last;
          end
        end
      end
    end
    nxt_bit = nxt_data[nxt_idx];
  end

  // Byte, counters and shadow register; reset discards any held shadow byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q        <= 8'h00;
      last_q        <= 1'b0;
      idx_q         <= 3'd7;
      half_q        <= 1'b0;
      shadow_q      <= 8'h00;
      shadow_last_q <= 1'b0;
      shadow_vld_q  <= 1'b0;
    end else begin
      data_q <= nxt_data;
      last_q <= nxt_last;
      idx_q  <= nxt_idx;
      half_q <= nxt_half;
      if (step & byte_done) begin
        shadow_vld_q <= 1'b0;
      end else if (shadow_wr) begin
        shadow_q      <= wr_data;
        shadow_last_q <= wr_last;
        shadow_vld_q  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/maple_tx.sv
// Maple bus line transmitter: start pattern, alternating-phase data bits, end pattern on pin1/pin5.
// Latency: first line change on the first tick strictly after the IDLE handshake; one sub-phase per tick.
// Backpressure: tx_ready in IDLE and during bit 0 of a non-last byte; missing data ends the frame with underrun.
module maple_tx
  import maple_pkg::*;
#(
  parameter int START_PULSES = DEF_START_PULSES,
  parameter int END_PULSES   = DEF_END_PULSES
) (
  input  logic       clk,
  input  logic       rst,
  maple_tx_if.slave  bus
);

  localparam logic [PULSE_W-1:0] S_P = PULSE_W'(START_PULSES);
  localparam logic [PULSE_W-1:0] E_P = PULSE_W'(END_PULSES);

  state_e             state_q;
  logic [PULSE_W-1:0] pcnt_q;
  logic               hi_q;
  logic               pin1_q, pin5_q, oe_q, busy_q, ready_q, urun_q;

  logic       hs, cont, byte_done, shadow_full, last_flag;
  logic       ld, begin_data, step, shadow_wr;
  logic [2:0] nxt_idx;
  logic       nxt_half, nxt_bit;

  assign hs         = bus.tx_valid & ready_q;
  assign cont       = shadow_full | hs;
  assign ld         = (state_q == ST_IDLE) & hs;
  assign begin_data = (state_q == ST_START) & bus.tick & (pcnt_q > S_P);
  assign step       = (state_q == ST_DATA) & bus.tick & (~byte_done | (~last_flag & cont));
  assign shadow_wr  = (state_q == ST_DATA) & hs;

  maple_tx_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .ld         (ld),
    .ld_data    (bus.tx_data),
    .ld_last    (bus.tx_last),
    .begin_data (begin_data),
    .step       (step),
    .shadow_wr  (shadow_wr),
    .wr_data    (bus.tx_data),
    .wr_last    (bus.tx_last),
    .byte_done  (byte_done),
    .shadow_full(shadow_full),
    .last_flag  (last_flag),
    .nxt_idx    (nxt_idx),
    .nxt_half   (nxt_half),
    .nxt_bit    (nxt_bit)
  );

  // Frame FSM with pattern counters; every line output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      hi_q    <= 1'b0;
      pin1_q  <= LINE_IDLE;
      pin5_q  <= LINE_IDLE;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      urun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (hs) begin
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else if (busy_q && bus.tick) begin
            state_q <= ST_START;
            oe_q    <= 1'b1;
            pin1_q  <= 1'b0;
            pin5_q  <= 1'b0;
            pcnt_q  <= PULSE_W'(1);
            hi_q    <= 1'b0;
          end else if (!busy_q) begin
            ready_q <= 1'b1;
          end
        end
        ST_START: begin
          if (bus.tick) begin
            if (pcnt_q > S_P) begin
              state_q          <= ST_DATA;
              {pin1_q, pin5_q} <= data_lines(nxt_idx, nxt_half, nxt_bit);
            end else if (!hi_q) begin
              hi_q   <= 1'b1;
              pin5_q <= 1'b1;
            end else if (pcnt_q < S_P) begin
              pcnt_q <= pcnt_q + 1'b1;
              hi_q   <= 1'b0;
              pin5_q <= 1'b0;
            end else begin
              pcnt_q <= pcnt_q + 1'b1;
              pin1_q <= 1'b1;
              pin5_q <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (hs) ready_q <= 1'b0;
          if (bus.tick) begin
            if (byte_done && (last_flag || !cont)) begin
              state_q <= ST_END;
              pin1_q  <= 1'b0;
              pin5_q  <= 1'b0;
              pcnt_q  <= PULSE_W'(1);
              hi_q    <= 1'b0;
              ready_q <= 1'b0;
              urun_q  <= ~last_flag;
            end else begin
              {pin1_q, pin5_q} <= data_lines(nxt_idx, nxt_half, nxt_bit);
              ready_q <= (nxt_idx == 3'd0) & ~nxt_half & ~last_flag;
            end
          end
        end
        ST_END: begin
          if (bus.tick) begin
            if (!hi_q) begin
              hi_q   <= 1'b1;
              pin1_q <= 1'b1;
            end else if (pcnt_q < E_P) begin
              pcnt_q <= pcnt_q + 1'b1;
              hi_q   <= 1'b0;
              pin1_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              pin1_q  <= LINE_IDLE;
              pin5_q  <= LINE_IDLE;
              oe_q    <= 1'b0;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.pin1     = pin1_q;
  assign bus.pin5     = pin5_q;
  assign bus.oe       = oe_q;
  assign bus.busy     = busy_q;
  assign bus.tx_ready = ready_q;
  assign bus.underrun = urun_q;

endmodule

// File: tb/tb_maple_tx.sv
// Self-checking bench for maple_tx: per-tick line sequence against a pattern model built from the bus rules.
// Latency: n/a.
// Backpressure: bench host presents bytes early or exactly on the bit 0 falling phase, or withholds them.
module tb_maple_tx;

  localparam int S = 4;
  localparam int E = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maple_tx_if bus ();

  maple_tx #(.START_PULSES(S), .END_PULSES(E)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] bytes[4];
  int         mode[4];      // 0: present early, 1: present on the bit 0 tick b cycle
  logic [2:0] exp_q[$];     // expected {pin1, pin5, oe} after each tick of a frame

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line pattern of a whole frame, straight from the bus rules.
  task automatic build_exp(input int n);
    logic d;
    exp_q.delete();
    for (int i = 0; i < S; i++) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b011);
    end
    exp_q.push_back(3'b111);
    for (int k = 0; k < n; k++) begin
      for (int bi = 7; bi >= 0; bi--) begin
        d = bytes[k][bi];
        if (bi % 2 == 1) begin
          exp_q.push_back({1'b1, d, 1'b1});
          exp_q.push_back({1'b0, d, 1'b1});
        end else begin
          exp_q.push_back({d, 1'b1, 1'b1});
          exp_q.push_back({d, 1'b0, 1'b1});
        end
      end
    end
    for (int i = 0; i < E; i++) begin
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b101);
    end
    exp_q.push_back(3'b110);
  endtask

  task automatic fill_rand(input int nb);
    for (int k = 0; k < nb; k++) begin
      bytes[k] = 8'($urandom);
      mode[k]  = $urandom_range(0, 1);
    end
  endtask

  // One frame of nb bytes; urun leaves tx_last low on the final byte. abort_at>0 resets after that tick.
  task automatic run_frame(input int nb, input bit urun, input int tmin, input int tmax,
                           input int abort_at);
    int acc, tidx, cd, urun_cnt, cyc_cnt, ei;
    bit started, pre_started, done, tk, tvld, hs;
    logic [3:0] expv;
    acc = 0; tidx = 0; urun_cnt = 0; cyc_cnt = 0;
    started = 0; done = 0;
    cd = (tmax == 1) ? 0 : $urandom_range(0, 1);
    build_exp(nb);
    while (!done && cyc_cnt < 4000) begin
      tk   = (cd == 0);
      tvld = 0;
      if (acc < nb) begin
        if (acc == 0 || mode[acc] == 0) tvld = 1;
        else tvld = tk && started && (tidx + 1 == 2 * S + 1 + 16 * acc);
      end
      bus.tick     = tk;
      bus.tx_valid = tvld;
      bus.tx_data  = (acc < nb) ? bytes[acc] : 8'h00;
      bus.tx_last  = !urun && (acc == nb - 1);
      hs           = tvld && (bus.tx_ready === 1'b1);
      pre_started  = started;
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (hs) begin
        acc++;
        started = 1;
      end
      if (tk && pre_started) tidx++;
      cd = tk ? $urandom_range(tmin, tmax) - 1 : cd - 1;
      if (bus.underrun === 1'b1) urun_cnt++;
      if (!started) begin
        expv = 4'b1100;
      end else if (tidx == 0) begin
        expv = 4'b1101;
      end else begin
        ei   = (tidx > exp_q.size()) ? exp_q.size() : tidx;
        expv = {exp_q[ei - 1], (tidx < exp_q.size()) ? 1'b1 : 1'b0};
      end
      chk("lines", {bus.pin1, bus.pin5, bus.oe, bus.busy}, expv);
      if (tidx >= exp_q.size()) done = 1;
      if (abort_at > 0 && tidx == abort_at) begin
        bus.tick     = 0;
        bus.tx_valid = 0;
        rst          = 1;
        @(posedge clk);
        #1;
        chk("rst_mid", {bus.pin1, bus.pin5, bus.oe, bus.busy, bus.tx_ready, bus.underrun},
            6'b110000);
        rst = 0;
        return;
      end
    end
    bus.tick     = 0;
    bus.tx_valid = 0;
    chk("frame_ticks", tidx, exp_q.size());
    chk("accepted", acc, nb);
    chk("underrun", urun_cnt, urun ? 1 : 0);
    chk("ready_end", {bus.tx_ready, bus.busy}, 2'b10);
  endtask

  initial begin
    bus.tick     = 0;
    bus.tx_valid = 0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 0;
    rst          = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {bus.pin1, bus.pin5, bus.oe, bus.busy, bus.tx_ready, bus.underrun}, 6'b110000);
    rst = 0;
    @(posedge clk);
    #1;

    // Idle with the divider running: lines released, ready for a frame.
    for (int i = 0; i < 100; i++) begin
      bus.tick = (i % 4 == 0);
      @(posedge clk);
      #1;
      chk("idle", {bus.pin1, bus.pin5, bus.oe, bus.busy, bus.tx_ready, bus.underrun}, 6'b110010);
    end
    bus.tick = 0;

    // Single byte 0xA5, tick every 4 clocks.
    bytes[0] = 8'hA5; mode[0] = 0;
    run_frame(1, 0, 4, 4, 0);

    // Three back-to-back bytes.
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    mode[0] = 0; mode[1] = 0; mode[2] = 0;
    run_frame(3, 0, 4, 4, 0);

    // Second byte arrives too late: first frame underruns, the byte then forms its own frame.
    fill_rand(1);
    run_frame(1, 1, 2, 5, 0);
    fill_rand(1);
    run_frame(1, 0, 2, 5, 0);

    // Reset during bit 3 tick a of the first byte, then a clean frame.
    fill_rand(2);
    run_frame(2, 0, 2, 5, 2 * S + 1 + 9);
    fill_rand(2);
    run_frame(2, 0, 2, 5, 0);

    // Next bytes handed over exactly on bit 0 tick b.
    fill_rand(3);
    mode[1] = 1; mode[2] = 1;
    run_frame(3, 0, 2, 5, 0);

    // Tick stuck high: one sub-phase per clock, both presentation styles.
    fill_rand(3);
    mode[1] = 0; mode[2] = 1;
    run_frame(3, 0, 1, 1, 0);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      int nb;
      bit ur;
      nb = $urandom_range(1, 4);
      ur = ($urandom_range(0, 4) == 0);
      fill_rand(nb);
      run_frame(nb, ur, 2, 5, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
